lock_entry_ctrl: RTL and testbench



---
 rtl/lock_entry_ctrl.sv | 87 ++++++++
 tb/tb_lock_entry_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lock_entry_ctrl.sv
// lock_entry_ctrl: sequential front end for the combinational Lock checker.
// Captures a code on enter, presents it registered to Lock, samples z one
// cycle later and runs the open / retry / lockout sequence.
module lock_entry_ctrl #(
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned LOCKOUT_CYCLES = 16,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic [5:0] code_in,
    input  logic       z_in,
    output logic [5:0] lock_code,
    output logic       open,
    output logic       alarm,
    output logic       busy,
    output logic [1:0] fail_cnt
);

    localparam int unsigned MaxCycles =
        (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    // Timer holds at most MaxCycles-1, so clog2(MaxCycles) bits suffice.
    localparam int unsigned TimerW = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StOpen, StLockout} state_e;

    state_e              state_q;
    logic [TimerW-1:0]   timer_q;
    logic [5:0]          lock_code_q;
    logic [1:0]          fail_cnt_q;
    logic                last_fail;

    // This failure would be the one that reaches the lockout threshold.
    assign last_fail = (32'(fail_cnt_q) + 32'd1) >= MAX_FAILS;

    // Main FSM: code capture, z sampling, open/lockout timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            lock_code_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enter) begin
                        lock_code_q <= code_in;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (z_in) begin
                        fail_cnt_q <= '0;
                        timer_q    <= TimerW'(OPEN_CYCLES - 1);
                        state_q    <= StOpen;
                    end else if (last_fail) begin
                        fail_cnt_q <= '0;
                        timer_q    <= TimerW'(LOCKOUT_CYCLES - 1);
                        state_q    <= StLockout;
                    end else begin
                        fail_cnt_q <= fail_cnt_q + 2'd1;
                        state_q    <= StIdle;
                    end
                end
                StOpen, StLockout: begin
                    // enter is ignored here, including on the return edge.
                    if (timer_q == '0) begin
                        lock_code_q <= '0;
                        state_q     <= StIdle;
                    end else begin
                        timer_q <= timer_q - TimerW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decoded from registered state only; reset drops them at once.
    assign lock_code = lock_code_q;
    assign fail_cnt  = fail_cnt_q;
    assign open      = (state_q == StOpen);
    assign alarm     = (state_q == StLockout);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Directed bench for lock_entry_ctrl; expected per-cycle outputs are queued
// as stimulus is driven and popped after each rising edge.
module tb_lock_entry_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter = 1'b0;
    logic [5:0] code_in = 6'h00;
    logic       z_in;
    logic [5:0] lock_code;
    logic       open;
    logic       alarm;
    logic       busy;
    logic [1:0] fail_cnt;

    logic [5:0] secret = 6'b101010;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [5:0] code;
        logic       op;
        logic       al;
        logic       bz;
        logic [1:0] fc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational Lock checker.
    assign z_in = (lock_code == secret);

    lock_entry_ctrl #(
        .OPEN_CYCLES(8),
        .LOCKOUT_CYCLES(16),
        .MAX_FAILS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enter(enter),
        .code_in(code_in),
        .z_in(z_in),
        .lock_code(lock_code),
        .open(open),
        .alarm(alarm),
        .busy(busy),
        .fail_cnt(fail_cnt)
    );

    task automatic push(input string tag, input logic [5:0] code, input logic op,
                        input logic al, input logic bz, input logic [1:0] fc);
        exp_t e;
        e.tag  = tag;
        e.code = code;
        e.op   = op;
        e.al   = al;
        e.bz   = bz;
        e.fc   = fc;
        sb.push_back(e);
    endtask

    task automatic push_n(input int n, input string tag, input logic [5:0] code,
                          input logic op, input logic al, input logic bz,
                          input logic [1:0] fc);
        for (int i = 0; i < n; i++) push($sformatf("%s[%0d]", tag, i), code, op, al, bz, fc);
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cmp();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty: observed=0 entries expected>=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".lock_code"}, lock_code, e.code);
            chk({e.tag, ".open"}, {5'b0, open}, {5'b0, e.op});
            chk({e.tag, ".alarm"}, {5'b0, alarm}, {5'b0, e.al});
            chk({e.tag, ".busy"}, {5'b0, busy}, {5'b0, e.bz});
            chk({e.tag, ".fail_cnt"}, {4'b0, fail_cnt}, {4'b0, e.fc});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp();
    endtask

    initial begin
        // Reset held with enter asserted and an all-ones code.
        enter   = 1'b1;
        code_in = 6'h3F;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 6'h00, 0, 0, 0, 2'd0);
        cmp();

        // Release; the first enter is taken on the very next edge.
        code_in = 6'b101010;
        rst_n   = 1'b1;
        push("ok_check", 6'h2A, 0, 0, 1, 2'd0);
        tick();
        enter   = 1'b0;
        code_in = 6'h15;  // changes after capture must not reach lock_code
        push_n(8, "ok_open", 6'h2A, 1, 0, 1, 2'd0);
        push("ok_done", 6'h00, 0, 0, 0, 2'd0);
        repeat (9) tick();

        // Single failure, then a second enter accepted at k+2.
        enter   = 1'b1;
        code_in = 6'h01;
        push("f1_check", 6'h01, 0, 0, 1, 2'd0);
        tick();
        enter = 1'b0;
        push("f1_idle", 6'h01, 0, 0, 0, 2'd1);
        tick();
        enter   = 1'b1;
        code_in = 6'h02;
        push("f2_check", 6'h02, 0, 0, 1, 2'd1);
        tick();
        enter = 1'b0;
        push("f2_idle", 6'h02, 0, 0, 0, 2'd2);
        tick();

        // Third failure -> lockout; enter held high throughout is ignored.
        enter   = 1'b1;
        code_in = 6'h03;
        push("f3_check", 6'h03, 0, 0, 1, 2'd2);
        tick();
        code_in = 6'h3F;
        push_n(16, "lock_alarm", 6'h03, 0, 1, 1, 2'd0);
        push("lock_done", 6'h00, 0, 0, 0, 2'd0);
        repeat (17) tick();
        enter = 1'b0;
        push("lock_idle", 6'h00, 0, 0, 0, 2'd0);
        tick();

        // Two failures then a correct code.
        enter   = 1'b1;
        code_in = 6'h04;
        push("fs1_check", 6'h04, 0, 0, 1, 2'd0);
        tick();
        enter = 1'b0;
        push("fs1_idle", 6'h04, 0, 0, 0, 2'd1);
        tick();
        enter   = 1'b1;
        code_in = 6'h05;
        push("fs2_check", 6'h05, 0, 0, 1, 2'd1);
        tick();
        enter = 1'b0;
        push("fs2_idle", 6'h05, 0, 0, 0, 2'd2);
        tick();
        enter   = 1'b1;
        code_in = 6'h2A;
        push("fs_ok_check", 6'h2A, 0, 0, 1, 2'd2);
        tick();
        enter = 1'b0;
        push_n(8, "fs_open", 6'h2A, 1, 0, 1, 2'd0);
        push("fs_done", 6'h00, 0, 0, 0, 2'd0);
        repeat (9) tick();

        // Fail once, then open and reset asynchronously in the 3rd open cycle.
        enter   = 1'b1;
        code_in = 6'h06;
        push("r_fail_check", 6'h06, 0, 0, 1, 2'd0);
        tick();
        enter = 1'b0;
        push("r_fail_idle", 6'h06, 0, 0, 0, 2'd1);
        tick();
        enter   = 1'b1;
        code_in = 6'h2A;
        push("r_check", 6'h2A, 0, 0, 1, 2'd1);
        tick();
        enter = 1'b0;
        push_n(3, "r_open", 6'h2A, 1, 0, 1, 2'd0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        push("r_async", 6'h00, 0, 0, 0, 2'd0);
        cmp();
        @(negedge clk);
        rst_n = 1'b1;
        push("r_idle", 6'h00, 0, 0, 0, 2'd0);
        tick();

        // After reset a failure counts from zero again.
        enter   = 1'b1;
        code_in = 6'h07;
        push("r_post_check", 6'h07, 0, 0, 1, 2'd0);
        tick();
        enter = 1'b0;
        push("r_post_idle", 6'h07, 0, 0, 0, 2'd1);
        tick();

        checks++;
        assert (sb.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_drain: observed=%0d entries expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
